// File: rtl/mac_unit_pipe.sv
// mac_unit_pipe: pipelined signed/unsigned multiply-accumulate cell with double-buffered weight,
// stall, saturation and a sticky overflow flag.
module mac_unit_pipe #(
    parameter int DATA_WIDTH        = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int LAST_SUM_WIDTH    = 16,
    parameter int PARTIAL_SUM_WIDTH = 24,
    parameter int SATURATE          = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         preload_weight,
    input  logic                         load_weight,
    input  logic [WEIGHT_WIDTH-1:0]      weight_in,
    output logic [WEIGHT_WIDTH-1:0]      weight_out,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         data_valid_in,
    input  logic                         signed_mode,
    output logic [DATA_WIDTH-1:0]        data_out,
    input  logic [LAST_SUM_WIDTH-1:0]    last_sum,
    output logic [PARTIAL_SUM_WIDTH-1:0] partial_sum,
    output logic                         valid_out,
    output logic                         overflow,
    input  logic                         clear_ovf
);
    localparam int PW = PARTIAL_SUM_WIDTH;
    localparam int PD = DATA_WIDTH + WEIGHT_WIDTH;

    logic [WEIGHT_WIDTH-1:0] shadow, active;
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    v1, s1, v2, s2;
    logic [PD-1:0]           dx, wx, prod, prod_r;
    logic [PW:0]             px, lx, sum;
    logic [PW-1:0]           lim, res;
    logic                    ovf;

    // Operands extended to the full product width so one multiplier serves both modes
    always_comb begin
        dx   = {{WEIGHT_WIDTH{s1 & data_r[DATA_WIDTH-1]}}, data_r};
        wx   = {{DATA_WIDTH{s1 & active[WEIGHT_WIDTH-1]}}, active};
        prod = dx * wx;
        px   = {{(PW+1-PD){s2 & prod_r[PD-1]}}, prod_r};
        lx   = {{(PW+1-LAST_SUM_WIDTH){s2 & last_sum[LAST_SUM_WIDTH-1]}}, last_sum};
        sum  = px + lx;
        ovf  = s2 ? sum[PW] ^ sum[PW-1] : sum[PW];
        lim  = !s2 ? {PW{1'b1}} : sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        res  = (SATURATE != 0 && ovf) ? lim : sum[PW-1:0];
    end

    // Both updates read the pre-edge shadow, so load+preload moves the old shadow to active
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (load_weight) active <= shadow;
            if (preload_weight) shadow <= weight_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r      <= '0;
            v1          <= 1'b0;
            s1          <= 1'b0;
            prod_r      <= '0;
            v2          <= 1'b0;
            s2          <= 1'b0;
            partial_sum <= '0;
            valid_out   <= 1'b0;
        end else if (enable) begin
            data_r      <= data_in;
            v1          <= data_valid_in;
            s1          <= signed_mode;
            prod_r      <= prod;
            v2          <= v1;
            s2          <= s1;
            partial_sum <= res;
            valid_out   <= v2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow <= 1'b0;
        else if (enable && v2 && ovf) overflow <= 1'b1;
        else if (clear_ovf) overflow <= 1'b0;
    end

    assign weight_out = shadow;
    assign data_out   = data_r;
endmodule

// File: tb/tb_mac_unit_pipe.sv
// tb_mac_unit_pipe: checks three mac_unit_pipe configurations (24-bit saturating, 16-bit
// saturating, 16-bit wrapping) against a sample-level arithmetic reference model.
module tb_mac_unit_pipe;
    logic clk = 0, rst = 0, enable = 0, preload_weight = 0, load_weight = 0;
    logic data_valid_in = 0, signed_mode = 0, clear_ovf = 0;
    logic [7:0] weight_in = 0, data_in = 0;
    logic [15:0] last_sum = 0;
    logic [23:0] ps0;
    logic [15:0] ps1, ps2;
    logic [7:0] do0, do1, do2, wo0, wo1, wo2;
    logic vo0, vo1, vo2, ov0, ov1, ov2;
    logic [109:0] obs_all;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mac_unit_pipe u0 (.clk(clk), .rst(rst), .enable(enable), .preload_weight(preload_weight),
        .load_weight(load_weight), .weight_in(weight_in), .weight_out(wo0), .data_in(data_in),
        .data_valid_in(data_valid_in), .signed_mode(signed_mode), .data_out(do0),
        .last_sum(last_sum), .partial_sum(ps0), .valid_out(vo0), .overflow(ov0), .clear_ovf(clear_ovf));
    mac_unit_pipe #(.PARTIAL_SUM_WIDTH(16), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .enable(enable),
        .preload_weight(preload_weight), .load_weight(load_weight), .weight_in(weight_in),
        .weight_out(wo1), .data_in(data_in), .data_valid_in(data_valid_in), .signed_mode(signed_mode),
        .data_out(do1), .last_sum(last_sum), .partial_sum(ps1), .valid_out(vo1), .overflow(ov1),
        .clear_ovf(clear_ovf));
    mac_unit_pipe #(.PARTIAL_SUM_WIDTH(16), .SATURATE(0)) u2 (.clk(clk), .rst(rst), .enable(enable),
        .preload_weight(preload_weight), .load_weight(load_weight), .weight_in(weight_in),
        .weight_out(wo2), .data_in(data_in), .data_valid_in(data_valid_in), .signed_mode(signed_mode),
        .data_out(do2), .last_sum(last_sum), .partial_sum(ps2), .valid_out(vo2), .overflow(ov2),
        .clear_ovf(clear_ovf));

    assign obs_all = {ps0, vo0, ov0, do0, wo0, ps1, vo1, ov1, do1, wo1, ps2, vo2, ov2, do2, wo2};

    // Each accepted pipeline slot is one sample; w is the weight it gets multiplied by
    typedef struct {logic [7:0] d; logic s; logic v; logic [7:0] w;} smp_t;
    smp_t q[$];
    logic [7:0] m_sh, m_act;
    logic [23:0] e_ps0;
    logic [15:0] e_ps1, e_ps2;
    logic e_v;
    logic e_o [3];

    function automatic longint exact(smp_t e, logic [15:0] ls);
        byte bd, bw;
        shortint sl;
        bd = e.d;
        bw = e.w;
        sl = ls;
        if (e.s) return longint'(bd) * longint'(bw) + longint'(sl);
        return longint'(e.d) * longint'(e.w) + longint'(ls);
    endfunction

    function automatic logic [24:0] resolve(longint x, logic s, int pw, int sat);
        longint mx, mn, r;
        logic ov;
        mx = s ? (longint'(1) <<< (pw - 1)) - 1 : (longint'(1) <<< pw) - 1;
        mn = s ? -(longint'(1) <<< (pw - 1)) : 0;
        ov = (x > mx) || (x < mn);
        r = (ov && sat != 0) ? ((x > mx) ? mx : mn) : x;
        return {ov, r[23:0]};
    endfunction

    function automatic logic [109:0] exp_vec();
        logic [7:0] d;
        d = q[1].d;
        return {e_ps0, e_v, e_o[0], d, m_sh, e_ps1, e_v, e_o[1], d, m_sh, e_ps2, e_v, e_o[2], d, m_sh};
    endfunction

    task automatic model_reset();
        smp_t z;
        z = '{d: 0, s: 0, v: 0, w: 0};
        m_sh = 0;
        m_act = 0;
        q.delete();
        q.push_back(z);
        q.push_back(z);
        e_ps0 = 0; e_ps1 = 0; e_ps2 = 0; e_v = 0;
        e_o = '{0, 0, 0};
    endtask

    task automatic model_edge();
        logic [7:0] act_old;
        logic [24:0] r0, r1, r2;
        longint x;
        smp_t t, n;
        act_old = m_act;
        if (load_weight) m_act = m_sh;
        if (preload_weight) m_sh = weight_in;
        if (enable) begin
            t = q[1];
            t.w = act_old;
            q[1] = t;
            x = exact(q[0], last_sum);
            r0 = resolve(x, q[0].s, 24, 1);
            r1 = resolve(x, q[0].s, 16, 1);
            r2 = resolve(x, q[0].s, 16, 0);
            e_ps0 = r0[23:0]; e_ps1 = r1[15:0]; e_ps2 = r2[15:0]; e_v = q[0].v;
            e_o[0] = (q[0].v && r0[24]) ? 1'b1 : clear_ovf ? 1'b0 : e_o[0];
            e_o[1] = (q[0].v && r1[24]) ? 1'b1 : clear_ovf ? 1'b0 : e_o[1];
            e_o[2] = (q[0].v && r2[24]) ? 1'b1 : clear_ovf ? 1'b0 : e_o[2];
            void'(q.pop_front());
            n = '{d: data_in, s: signed_mode, v: data_valid_in, w: 0};
            q.push_back(n);
        end else if (clear_ovf) e_o = '{0, 0, 0};
    endtask

    task automatic tick(input logic en, pre, ld, input logic [7:0] w, d, input logic dv, sm,
                        input logic [15:0] ls, input logic clr);
        enable = en; preload_weight = pre; load_weight = ld; weight_in = w; data_in = d;
        data_valid_in = dv; signed_mode = sm; last_sum = ls; clear_ovf = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        enable = 1; preload_weight = 1; load_weight = 1; weight_in = 55; data_in = 77; data_valid_in = 1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs_all !== 110'b0) begin bad++; $display("FAIL reset_zero got=%h want=0", obs_all); end
        total++;
        if (obs_all !== exp_vec()) begin bad++; $display("FAIL reset_model got=%h want=%h", obs_all, exp_vec()); end
        rst = 1;
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_unsigned();
        tick(1, 1, 0, 200, 0, 0, 0, 5, 0);
        tick(1, 0, 1, 0, 0, 0, 0, 5, 0);
        tick(1, 0, 0, 0, 100, 1, 0, 5, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 5, 0);
        total++;
        if (vo0 !== 1'b0) begin bad++; $display("FAIL unsigned_early_valid got=%b want=0", vo0); end
        tick(1, 0, 0, 0, 0, 0, 0, 5, 0);
        total++;
        if (ps0 !== 24'd20005 || vo0 !== 1'b1)
            begin bad++; $display("FAIL unsigned_result got=%0d/%b want=20005/1", ps0, vo0); end
        total++;
        if (obs_all !== exp_vec()) begin bad++; $display("FAIL unsigned_all got=%h want=%h", obs_all, exp_vec()); end
    endtask

    task automatic test_signed();
        tick(1, 1, 0, 8'hFD, 0, 0, 1, 16'hFFFF, 0);
        tick(1, 0, 1, 0, 0, 0, 1, 16'hFFFF, 0);
        tick(1, 0, 0, 0, 8'h80, 1, 1, 16'hFFFF, 0);
        repeat (2) tick(1, 0, 0, 0, 0, 0, 1, 16'hFFFF, 0);
        total++;
        if (ps0 !== 24'd383 || vo0 !== 1'b1) begin bad++; $display("FAIL signed_383 got=%0d/%b want=383/1", ps0, vo0); end
        tick(1, 1, 0, 8'd127, 0, 0, 1, 16'h8000, 0);
        tick(1, 0, 1, 0, 0, 0, 1, 16'h8000, 0);
        tick(1, 0, 0, 0, 8'h80, 1, 1, 16'h8000, 0);
        repeat (2) tick(1, 0, 0, 0, 0, 0, 1, 16'h8000, 0);
        total++;
        if (ps0 !== 24'hFF4080 || ov0 !== 1'b0)
            begin bad++; $display("FAIL signed_neg got=%h/%b want=ff4080/0", ps0, ov0); end
        total++;
        if (ps1 !== 16'h8000 || ov1 !== 1'b1 || ps2 !== 16'h4080 || ov2 !== 1'b1)
            begin bad++; $display("FAIL signed_narrow got=%h/%b %h/%b want=8000/1 4080/1", ps1, ov1, ps2, ov2); end
        total++;
        if (obs_all !== exp_vec()) begin bad++; $display("FAIL signed_all got=%h want=%h", obs_all, exp_vec()); end
    endtask

    task automatic test_double_buffer();
        logic [23:0] want [3];
        want = '{24'd2, 24'd2, 24'd7};
        tick(1, 1, 0, 2, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 7, 1, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 1, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ps0 !== want[i] || vo0 !== 1'b1)
                begin bad++; $display("FAIL dbuf_seq%0d got=%0d/%b want=%0d/1", i, ps0, vo0, want[i]); end
            total++;
            if (obs_all !== exp_vec()) begin bad++; $display("FAIL dbuf_all%0d got=%h want=%h", i, obs_all, exp_vec()); end
            tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        tick(1, 1, 0, 5, 0, 0, 0, 0, 0);
        tick(1, 1, 1, 9, 0, 0, 0, 0, 0);
        total++;
        if (wo0 !== 8'd9) begin bad++; $display("FAIL dbuf_shadow got=%0d want=9", wo0); end
        tick(1, 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (2) tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (ps0 !== 24'd5) begin bad++; $display("FAIL dbuf_same_cycle got=%0d want=5", ps0); end
    endtask

    task automatic test_saturation();
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++;
        if ({ov0, ov1, ov2} !== 3'b000) begin bad++; $display("FAIL sat_pre_clear got=%b want=000", {ov0, ov1, ov2}); end
        tick(1, 1, 0, 255, 0, 0, 0, 16'hFFFF, 0);
        tick(1, 0, 1, 0, 0, 0, 0, 16'hFFFF, 0);
        tick(1, 0, 0, 0, 255, 1, 0, 16'hFFFF, 0);
        repeat (2) tick(1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 0);
        total++;
        if (ps1 !== 16'hFFFF || ov1 !== 1'b1) begin bad++; $display("FAIL sat_clamp got=%0d/%b want=65535/1", ps1, ov1); end
        total++;
        if (ps2 !== 16'd65024 || ov2 !== 1'b1) begin bad++; $display("FAIL sat_wrap got=%0d/%b want=65024/1", ps2, ov2); end
        total++;
        if (ps0 !== 24'd130560 || ov0 !== 1'b0) begin bad++; $display("FAIL sat_wide got=%0d/%b want=130560/0", ps0, ov0); end
        tick(1, 0, 0, 0, 255, 1, 0, 16'hFFFF, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 1);
        total++;
        if (ov1 !== 1'b1 || ov2 !== 1'b1) begin bad++; $display("FAIL sat_set_wins got=%b%b want=11", ov1, ov2); end
        tick(1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 1);
        total++;
        if (ov1 !== 1'b0 || ov2 !== 1'b0) begin bad++; $display("FAIL sat_clear got=%b%b want=00", ov1, ov2); end
        total++;
        if (obs_all !== exp_vec()) begin bad++; $display("FAIL sat_all got=%h want=%h", obs_all, exp_vec()); end
    endtask

    task automatic test_stall();
        logic [23:0] want [$];
        logic [23:0] got [$];
        logic [23:0] held;
        logic [7:0] w, d;
        logic en, dv;
        w = 8'($urandom_range(1, 255));
        tick(1, 1, 0, w, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 0, 0, 0);
        held = 0;
        for (int i = 0; i < 23; i++) begin
            en = !(i >= 8 && i < 11);
            dv = (i < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            d = 8'($urandom);
            if (en && dv) want.push_back(24'(d) * 24'(w));
            if (i == 8) held = e_ps0;
            tick(en, 0, 0, 0, d, dv, 0, 0, 0);
            if (en && vo0) got.push_back(ps0);
            if (!en) begin
                total++;
                if (ps0 !== held) begin bad++; $display("FAIL stall_frozen%0d got=%0d want=%0d", i, ps0, held); end
            end
            total++;
            if (obs_all !== exp_vec()) begin bad++; $display("FAIL stall_all%0d got=%h want=%h", i, obs_all, exp_vec()); end
        end
        total++;
        if (got.size() != want.size()) begin bad++; $display("FAIL stall_count got=%0d want=%0d", got.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== want[i]) begin bad++; $display("FAIL stall_order%0d got=%0d want=%0d", i, got[i], want[i]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                 1'($urandom_range(0, 7) == 0));
            total++;
            if (obs_all !== exp_vec()) begin bad++; $display("FAIL random%0d got=%h want=%h", i, obs_all, exp_vec()); end
        end
    endtask

    task automatic test_async_reset();
        tick(1, 1, 0, 33, 0, 0, 0, 16'd9, 0);
        tick(1, 0, 1, 0, 0, 0, 0, 16'd9, 0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 8'(i + 3), 1, 0, 16'd9, 0);
        total++;
        if (obs_all !== exp_vec()) begin bad++; $display("FAIL areset_pre got=%h want=%h", obs_all, exp_vec()); end
        #2 rst = 0;
        #1;
        model_reset();
        total++;
        if (obs_all !== 110'b0) begin bad++; $display("FAIL areset_zero got=%h want=0", obs_all); end
        #1 rst = 1;
        tick(1, 0, 0, 0, 50, 1, 0, 16'd123, 0);
        repeat (2) tick(1, 0, 0, 0, 0, 0, 0, 16'd123, 0);
        total++;
        if (ps0 !== 24'd123 || vo0 !== 1'b1) begin bad++; $display("FAIL areset_weight0 got=%0d/%b want=123/1", ps0, vo0); end
        total++;
        if (obs_all !== exp_vec()) begin bad++; $display("FAIL areset_all got=%h want=%h", obs_all, exp_vec()); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_double_buffer();
        test_saturation();
        test_stall();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
